// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared definitions for the multdiv issue controller: FSM states and the
// $rstatus exception codes also used by the ALU-overflow writeback logic.
package multdiv_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_BUSY  = 2'b10,
    ST_DONE  = 2'b11
  } md_state_e;

  localparam int          MD_TIMEOUT       = 40;
  localparam logic [4:0]  MD_RSTATUS_REG   = 5'd30;
  localparam logic [31:0] MD_MULT_EXC_CODE = 32'd4;
  localparam logic [31:0] MD_DIV_EXC_CODE  = 32'd5;

  function automatic logic [31:0] md_exc_code(input logic is_div,
                                              input logic [31:0] mult_code,
                                              input logic [31:0] div_code);
    return is_div ? div_code : mult_code;
  endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Bus between the issue controller (master) and the shared multdiv unit (slave).
interface multdiv_issue_ctrl_if;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;

  modport master (
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  md_result, md_exception, md_resultRDY
  );

  modport slave (
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output md_result, md_exception, md_resultRDY
  );
endinterface

// File: rtl/multdiv_issue_ctrl_md_timeout_counter.sv
// 6-bit BUSY-cycle counter; o_last flags the enabled cycle that reaches TIMEOUT.
module md_timeout_counter #(
  parameter int TIMEOUT = 40
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_clear,
  input  logic       i_enable,
  output logic [5:0] o_count,
  output logic       o_last
);

  logic [5:0] r_count;

  // Count register with synchronous clear taking priority over enable.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= 6'd0;
    end else if (i_clear) begin
      r_count <= 6'd0;
    end else if (i_enable) begin
      r_count <= r_count + 6'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
  assign o_last  = i_enable && (r_count == 6'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the shared multdiv unit: latches operands, pulses the
// start strobe, stalls the pipe until ready or timeout, then writes back once.
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int          TIMEOUT       = MD_TIMEOUT,
  parameter logic [4:0]  RSTATUS_REG   = MD_RSTATUS_REG,
  parameter logic [31:0] MULT_EXC_CODE = MD_MULT_EXC_CODE,
  parameter logic [31:0] DIV_EXC_CODE  = MD_DIV_EXC_CODE
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        i_req_valid,
  input  logic                        i_req_is_div,
  input  logic [31:0]                 i_req_opA,
  input  logic [31:0]                 i_req_opB,
  input  logic [4:0]                  i_req_rd,
  input  logic                        i_flush,
  multdiv_issue_ctrl_if.master        md,
  output logic                        o_stall,
  output logic                        o_wb_valid,
  output logic [4:0]                  o_wb_rd,
  output logic [31:0]                 o_wb_data,
  output logic                        o_busy
);

  md_state_e   r_state, w_state_nxt;
  logic [31:0] r_opA, r_opB, w_opA_nxt, w_opB_nxt;
  logic        r_is_div, w_is_div_nxt;
  logic [4:0]  r_rd, w_rd_nxt;
  logic        r_ctrl_mult, r_ctrl_div, w_ctrl_mult_nxt, w_ctrl_div_nxt;
  logic        r_wb_valid, w_wb_valid_nxt;
  logic [4:0]  r_wb_rd, w_wb_rd_nxt;
  logic [31:0] r_wb_data, w_wb_data_nxt;
  logic        w_cnt_clear, w_cnt_en, w_cnt_last, w_stall;
  logic [5:0]  w_count;

  md_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_en),
    .o_count  (w_count),
    .o_last   (w_cnt_last)
  );

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_opA       <= 32'd0;
      r_opB       <= 32'd0;
      r_is_div    <= 1'b0;
      r_rd        <= 5'd0;
      r_ctrl_mult <= 1'b0;
      r_ctrl_div  <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_opA       <= w_opA_nxt;
      r_opB       <= w_opB_nxt;
      r_is_div    <= w_is_div_nxt;
      r_rd        <= w_rd_nxt;
      r_ctrl_mult <= w_ctrl_mult_nxt;
      r_ctrl_div  <= w_ctrl_div_nxt;
      r_wb_valid  <= w_wb_valid_nxt;
      r_wb_rd     <= w_wb_rd_nxt;
      r_wb_data   <= w_wb_data_nxt;
    end
  end

  // Next-state, next-register values and the combinational stall.
  always_comb begin
    w_state_nxt     = r_state;
    w_opA_nxt       = r_opA;
    w_opB_nxt       = r_opB;
    w_is_div_nxt    = r_is_div;
    w_rd_nxt        = r_rd;
    w_ctrl_mult_nxt = 1'b0;
    w_ctrl_div_nxt  = 1'b0;
    w_wb_valid_nxt  = 1'b0;
    w_wb_rd_nxt     = r_wb_rd;
    w_wb_data_nxt   = r_wb_data;
    w_cnt_clear     = 1'b0;
    w_cnt_en        = 1'b0;
    w_stall         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid && !i_flush) begin
          w_stall         = 1'b1;
          w_opA_nxt       = i_req_opA;
          w_opB_nxt       = i_req_opB;
          w_is_div_nxt    = i_req_is_div;
          w_rd_nxt        = i_req_rd;
          w_ctrl_mult_nxt = !i_req_is_div;
          w_ctrl_div_nxt  = i_req_is_div;
          w_state_nxt     = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        w_stall     = 1'b1;
        w_cnt_clear = 1'b1;
        if (i_flush) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_stall  = 1'b1;
        w_cnt_en = 1'b1;
        // A ready seen while the count is still zero belongs to a previous op.
        if (i_flush) begin
          w_state_nxt = ST_IDLE;
        end else if (md.md_resultRDY && (w_count != 6'd0)) begin
          w_state_nxt    = ST_DONE;
          w_wb_valid_nxt = 1'b1;
          if (md.md_exception) begin
            w_wb_rd_nxt   = RSTATUS_REG;
            w_wb_data_nxt = md_exc_code(r_is_div, MULT_EXC_CODE, DIV_EXC_CODE);
          end else begin
            w_wb_rd_nxt   = r_rd;
            w_wb_data_nxt = md.md_result;
          end
        end else if (w_cnt_last) begin
          w_state_nxt    = ST_DONE;
          w_wb_valid_nxt = 1'b1;
          w_wb_rd_nxt    = RSTATUS_REG;
          w_wb_data_nxt  = md_exc_code(r_is_div, MULT_EXC_CODE, DIV_EXC_CODE);
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign md.md_operandA  = r_opA;
  assign md.md_operandB  = r_opB;
  assign md.md_ctrl_MULT = r_ctrl_mult;
  assign md.md_ctrl_DIV  = r_ctrl_div;

  assign o_stall    = w_stall;
  assign o_wb_valid = r_wb_valid && !i_flush;
  assign o_wb_rd    = r_wb_rd;
  assign o_wb_data  = r_wb_data;
  assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench: a behavioural multdiv model plus per-operation expectations
// derived from cycle arithmetic (accept, start, >=2 busy cycles, writeback).
module tb_multdiv_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_is_div, flush;
  logic [31:0] req_opA, req_opB;
  logic [4:0]  req_rd;
  logic        stall, wb_valid, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int          n_checks = 0;
  int          n_errors = 0;

  multdiv_issue_ctrl_if md_bus ();

  multdiv_issue_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_req_valid  (req_valid),
    .i_req_is_div (req_is_div),
    .i_req_opA    (req_opA),
    .i_req_opB    (req_opB),
    .i_req_rd     (req_rd),
    .i_flush      (flush),
    .md           (md_bus),
    .o_stall      (stall),
    .o_wb_valid   (wb_valid),
    .o_wb_rd      (wb_rd),
    .o_wb_data    (wb_data),
    .o_busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (!is_div) return a * b;
    if (b == 32'd0) return 32'd0;
    return 32'(sa / sb);
  endfunction

  // Multdiv model: real ready one cycle at (1 + lat); optional stale ready in cycle 2.
  function automatic bit real_rdy(input int c, input int lat);
    return (lat >= 0) && (c == 1 + lat);
  endfunction

  // One instruction presented at cycle 0 in IDLE. lat<0: never ready.
  // f: cycle where flush is asserted (<0 none). tail: run one idle cycle after.
  task automatic run_op(input string tag, input bit is_div, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int lat,
                        input bit stale, input int f, input bit tail);
    int done_c, end_c, win, last_stall;
    bit aborted, suppressed, timed_out, exc_exp, div0, r_now, s_now;
    logic [31:0] res, data_exp;
    logic [4:0] rd_exp;
    int n_mult, n_div, pulse_c, n_wb, wb_c, n_stall, opnd_bad;
    logic [4:0] wb_rd_o;
    logic [31:0] wb_data_o;
    logic busy_after;
    n_mult = 0; n_div = 0; pulse_c = -1; n_wb = 0; wb_c = -1; n_stall = 0; opnd_bad = 0;
    wb_rd_o = 5'd0; wb_data_o = 32'd0; busy_after = 1'b1;
    res  = ref_result(is_div, a, b);
    div0 = is_div && (b == 32'd0);
    done_c = -1;
    for (int c = 3; c <= 41; c++)
      if (done_c < 0 && real_rdy(c, lat)) done_c = c + 1;
    timed_out  = (done_c < 0);
    if (timed_out) done_c = 42;
    exc_exp    = timed_out || div0;
    aborted    = (f >= 1) && (f < done_c);
    suppressed = (f == done_c);
    end_c      = aborted ? f : done_c;
    last_stall = aborted ? f : done_c - 1;
    win        = tail ? end_c + 1 : end_c;
    rd_exp     = exc_exp ? 5'd30 : rd;
    data_exp   = exc_exp ? (is_div ? 32'd5 : 32'd4) : res;

    for (int c = 0; c <= win; c++) begin
      @(negedge clock);
      r_now      = real_rdy(c, lat);
      s_now      = stale && (c == 2);
      req_valid  = (c <= end_c);
      req_is_div = is_div;
      req_opA    = a;
      req_opB    = b;
      req_rd     = rd;
      flush      = (c == f);
      md_bus.md_resultRDY = r_now || s_now;
      md_bus.md_exception = r_now && div0;
      md_bus.md_result    = r_now ? res : 32'hDEAD_BEEF;
      #1;
      if (md_bus.md_ctrl_MULT) begin n_mult++; pulse_c = c; end
      if (md_bus.md_ctrl_DIV)  begin n_div++;  pulse_c = c; end
      if (stall) n_stall++;
      if (wb_valid) begin n_wb++; wb_c = c; wb_rd_o = wb_rd; wb_data_o = wb_data; end
      if (c >= 1 && (md_bus.md_operandA !== a || md_bus.md_operandB !== b)) opnd_bad++;
      if (c == end_c + 1) busy_after = busy;
    end
    md_bus.md_resultRDY = 1'b0;
    md_bus.md_exception = 1'b0;

    check({tag, ".mult_pulses"}, 64'(n_mult), is_div ? 64'd0 : 64'd1);
    check({tag, ".div_pulses"},  64'(n_div),  is_div ? 64'd1 : 64'd0);
    check({tag, ".pulse_cycle"}, 64'(pulse_c), 64'd1);
    check({tag, ".stall_cycles"}, 64'(n_stall), 64'(last_stall + 1));
    check({tag, ".operands_held"}, 64'(opnd_bad), 64'd0);
    check({tag, ".wb_count"}, 64'(n_wb), (aborted || suppressed) ? 64'd0 : 64'd1);
    if (!aborted && !suppressed) begin
      check({tag, ".wb_cycle"}, 64'(wb_c), 64'(done_c));
      check({tag, ".wb_rd"}, 64'(wb_rd_o), 64'(rd_exp));
      check({tag, ".wb_data"}, 64'(wb_data_o), 64'(data_exp));
    end
    if (tail) check({tag, ".idle_after"}, 64'(busy_after), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".opA"}, 64'(md_bus.md_operandA), 64'd0);
    check({tag, ".opB"}, 64'(md_bus.md_operandB), 64'd0);
    check({tag, ".ctrl"}, 64'({md_bus.md_ctrl_MULT, md_bus.md_ctrl_DIV}), 64'd0);
    check({tag, ".wb_valid"}, 64'(wb_valid), 64'd0);
    check({tag, ".wb_rd"}, 64'(wb_rd), 64'd0);
    check({tag, ".wb_data"}, 64'(wb_data), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".stall"}, 64'(stall), 64'd0);
  endtask

  initial begin
    int ta, tb_, lat, f;
    bit is_div;
    reset_n = 1'b0; req_valid = 1'b0; req_is_div = 1'b0; flush = 1'b0;
    req_opA = 32'd0; req_opB = 32'd0; req_rd = 5'd0;
    md_bus.md_result = 32'd0; md_bus.md_exception = 1'b0; md_bus.md_resultRDY = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;

    run_op("mult7x-3", 1'b0, 32'd7, -32'sd3, 5'd5, 33, 1'b0, -1, 1'b1);
    run_op("div_by_0", 1'b1, 32'd10, 32'd0, 5'd9, 20, 1'b0, -1, 1'b1);
    run_op("flush_busy", 1'b0, 32'd2, 32'd9, 5'd3, 33, 1'b0, 10, 1'b1);
    run_op("mult6x6", 1'b0, 32'd6, 32'd6, 5'd7, 12, 1'b0, -1, 1'b1);
    run_op("flush_start", 1'b1, 32'd50, 32'd5, 5'd4, 10, 1'b0, 1, 1'b1);
    run_op("hang", 1'b0, 32'd11, 32'd13, 5'd8, -1, 1'b0, -1, 1'b1);
    run_op("stale_rdy", 1'b0, 32'd123, 32'd45, 5'd12, 33, 1'b1, -1, 1'b1);
    run_op("min_latency", 1'b1, -32'sd99, 32'd4, 5'd1, 2, 1'b1, -1, 1'b1);
    run_op("rdy_at_timeout", 1'b0, 32'd3, 32'd5, 5'd2, 40, 1'b0, -1, 1'b1);
    run_op("rd_zero", 1'b0, 32'd8, 32'd8, 5'd0, 5, 1'b0, -1, 1'b1);
    run_op("flush_done", 1'b1, 32'd77, 32'd7, 5'd6, 6, 1'b0, 8, 1'b1);
    run_op("b2b_div", 1'b1, 32'd100, 32'd7, 5'd10, 5, 1'b0, -1, 1'b0);
    run_op("b2b_mult", 1'b0, 32'd3, 32'd4, 5'd11, 4, 1'b0, -1, 1'b1);

    // Flush together with a request in IDLE: nothing is accepted.
    @(negedge clock);
    req_valid = 1'b1; flush = 1'b1; req_opA = 32'd1; req_opB = 32'd2;
    #1;
    check("idle_flush.stall", 64'(stall), 64'd0);
    @(negedge clock);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush.busy", 64'(busy), 64'd0);

    // Reset in the middle of an operation aborts it with no writeback.
    @(negedge clock);
    req_valid = 1'b1; req_is_div = 1'b0; req_opA = 32'd21; req_opB = 32'd2; req_rd = 5'd15;
    repeat (5) @(negedge clock);
    #1;
    check("pre_reset.busy", 64'(busy), 64'd1);
    reset_n = 1'b0; req_valid = 1'b0;
    @(negedge clock);
    #1;
    check_all_zero("mid_reset");
    reset_n = 1'b1;
    run_op("after_reset", 1'b1, 32'd81, 32'd9, 5'd20, 7, 1'b0, -1, 1'b1);

    for (int i = 0; i < 25; i++) begin
      is_div = 1'($urandom_range(0, 1));
      ta  = int'($urandom_range(0, 2000)) - 1000;
      tb_ = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 2000)) - 1000;
      lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(2, 45));
      f   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 43)) : -1;
      run_op($sformatf("rand%0d", i), is_div, 32'(ta), 32'(tb_), 5'($urandom_range(0, 31)),
             lat, 1'($urandom_range(0, 1)), f, 1'($urandom_range(0, 1)));
    end

    @(negedge clock);
    req_valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
